// File: rtl/sig_stream_serializer.sv
// rtl/sig_stream_serializer.sv - serializes a 520-bit signer result into a byte stream frame
// Frames are header(optional) + r,s,v MSB first; signer errors become a single 0xEE byte.
module sig_stream_serializer #(
  parameter int HEADER_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [519:0] sig_in,
  input  logic         sig_done,
  input  logic         sig_error,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         drop_flag,
  input  logic         clr_drop
);

  typedef enum logic [1:0] {IDLE, SEND, ERR} state_t;

  localparam int         HDR      = (HEADER_EN != 0) ? 1 : 0;
  localparam logic [6:0] LAST_IDX = 7'(64 + HDR);
  localparam logic [7:0] HDR_BYTE = 8'h5A;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  state_t         state;
  logic [519:0]   hold;
  logic [6:0]     cnt;
  logic           hs;
  logic           accept;
  logic           drop_evt;

  // Frame position idx maps to the header byte or payload byte k = idx - HDR.
  function automatic logic [7:0] byte_at(input logic [519:0] h, input logic [6:0] idx);
    int k;
    if (HDR == 1 && idx == 7'd0) return HDR_BYTE;
    k = int'(idx) - HDR;
    return h[519 - 8*k -: 8];
  endfunction

  // A new event is taken in IDLE or on the final-byte handshake, so frames can abut.
  assign hs       = out_valid && out_ready;
  assign accept   = (state == IDLE) || (hs && out_last);
  assign drop_evt = (sig_done || sig_error) && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (drop_evt)      drop_flag <= 1'b1;
      else if (clr_drop) drop_flag <= 1'b0;

      if (accept && sig_error) begin
        state     <= ERR;
        busy      <= 1'b1;
        cnt       <= '0;
        out_data  <= ERR_BYTE;
        out_valid <= 1'b1;
        out_last  <= 1'b1;
      end else if (accept && sig_done) begin
        state     <= SEND;
        busy      <= 1'b1;
        hold      <= sig_in;
        cnt       <= '0;
        out_data  <= byte_at(sig_in, 7'd0);
        out_valid <= 1'b1;
        out_last  <= 1'b0;
      end else if (hs && out_last) begin
        state     <= IDLE;
        busy      <= 1'b0;
        out_data  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (hs) begin
        cnt       <= cnt + 7'd1;
        out_data  <= byte_at(hold, cnt + 7'd1);
        out_last  <= ((cnt + 7'd1) == LAST_IDX);
      end
    end
  end

endmodule

// File: doc/sig_stream_serializer.md
SIG_STREAM_SERIALIZER -- requirements
Module: sig_stream_serializer

Interface
REQ-001 The block SHALL have parameter HEADER_EN, default 1: 1 = prepend one header byte 0x5A to every signature frame; 0 = no header.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port sig_in  input  520  signer result: r = [519:264], s = [263:8], v = [7:0].
REQ-005 The block SHALL have port sig_done  input  1  one-cycle pulse marking sig_in as valid.
REQ-006 The block SHALL have port sig_error  input  1  one-cycle pulse reporting a signer failure.
REQ-007 The block SHALL have port out_data  output  8  stream byte.
REQ-008 The block SHALL have port out_valid  output  1  out_data is valid.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the byte.
REQ-010 The block SHALL have port out_last  output  1  marks the final byte of a frame; qualified by out_valid.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port drop_flag  output  1  sticky; set when an event is discarded.
REQ-013 The block SHALL have port clr_drop  input  1  synchronous clear of drop_flag.

Function
REQ-014 The block SHALL implement the FSM states IDLE, SEND and ERR.
REQ-015 The block SHALL, in IDLE on sig_done=1 and sig_error=0, register sig_in into a 520-bit holding register, reset the byte counter to 0 and enter SEND.
REQ-016 The block SHALL, in IDLE on sig_error=1, enter ERR regardless of sig_done; error has priority.
REQ-017 The block SHALL assert out_valid in the cycle after the capturing edge; latency from the sig_done edge to the first out_valid is 1 cycle.
REQ-018 The block SHALL emit each SEND frame as: header 0x5A when HEADER_EN=1, then payload byte k = hold[519-8k -: 8] for k = 0..64 (r MSB first, then s, then v); frame length is 66 or 65 bytes.
REQ-019 The block SHALL emit each ERR frame as the single byte 0xEE with out_last=1, then return to IDLE.
REQ-020 The block SHALL advance the byte counter only when out_valid and out_ready are both 1 (a handshake).
REQ-021 The block SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 The block SHALL assert out_last exactly on the final byte of each frame and never on any other byte.
REQ-023 The block SHALL, on the final-byte handshake, go to IDLE; if sig_done or sig_error is high in that same cycle, it SHALL accept the event per REQ-015/REQ-016 instead, so back-to-back frames have no gap.
REQ-024 The block SHALL ignore sig_done or sig_error arriving in SEND or ERR outside the REQ-023 cycle, set drop_flag, and leave the current frame unaffected.
REQ-025 The block SHALL clear drop_flag on clr_drop=1; if a drop and clr_drop occur in the same cycle, the set wins.
REQ-026 The block SHALL ignore out_ready while out_valid=0; the byte counter never exceeds the frame length and never wraps.

Reset
REQ-027 The block SHALL, while rst_n=0, immediately force the state to IDLE and force out_valid, out_last, busy and drop_flag to 0, and the counter, out_data and the holding register to 0.
REQ-028 The block SHALL, on a reset mid-frame, abort the frame with no out_last; after release, the first event starts a fresh frame from byte 0.

Verification
REQ-029 The bench SHALL check: HEADER_EN=1, sig_done with r = 0x01..20 pattern, s = 0x21..40, v = 0x1B, out_ready tied to 1 -> 66 consecutive bytes 5A,01..40,1B; out_last only on 0x1B; busy high for 66 cycles.
REQ-030 The bench SHALL check: HEADER_EN=0, same vector, out_ready toggling 1-0-1 -> 65 bytes, no duplicates or skips, out_data stable across every stall cycle.
REQ-031 The bench SHALL check: sig_error pulse, and separately sig_done+sig_error together -> single byte 0xEE with out_last=1, back to IDLE, no signature bytes emitted.
REQ-032 The bench SHALL check: second sig_done at byte 10 of a frame -> drop_flag=1, first frame completes intact; clr_drop -> drop_flag=0.
REQ-033 The bench SHALL check: sig_done in the same cycle as the last-byte handshake -> the next frame's first byte is valid the following cycle, drop_flag stays 0.
REQ-034 The bench SHALL check: rst_n low at byte 30 -> out_valid=0 immediately, no out_last; a new sig_done after release -> a full frame from the header.
